// File: rtl/peak_pair_detect.sv
//==============================================================================
// Module      : peak_pair_detect
// Description : Finds the two largest local maxima in a framed sample stream
//               and publishes their indices and magnitudes at end of frame.
//               Optional macro PEAK_THRESHOLD_EN adds a minimum peak threshold.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module peak_pair_detect #(
  parameter int VALUE_WIDTH = 16,
  parameter int INDEX_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   valid,
  input  logic                   last,
  input  logic [VALUE_WIDTH-1:0] input_i,
  input  logic [INDEX_WIDTH-1:0] index_i,
`ifdef PEAK_THRESHOLD_EN
  input  logic [VALUE_WIDTH-1:0] threshold,
`endif
  output logic [31:0]            p_i_s,
  output logic [VALUE_WIDTH-1:0] peak_val1,
  output logic [VALUE_WIDTH-1:0] peak_val2,
  output logic [1:0]             peak_cnt,
  output logic                   last_out
);

  localparam logic [15:0] c_empty_idx = 16'hFFFF;
  localparam logic [1:0]  c_beat_full = 2'd2;

  logic [VALUE_WIDTH-1:0] r_prev1;
  logic [VALUE_WIDTH-1:0] r_prev2;
  logic [INDEX_WIDTH-1:0] r_prev1_idx;
  logic [1:0]             r_beat_cnt;

  logic [VALUE_WIDTH-1:0] r_top1_val;
  logic [INDEX_WIDTH-1:0] r_top1_idx;
  logic                   r_top1_vld;
  logic [VALUE_WIDTH-1:0] r_top2_val;
  logic [INDEX_WIDTH-1:0] r_top2_idx;
  logic                   r_top2_vld;

  logic                   w_above_thr;
  logic                   w_cand;
  logic [VALUE_WIDTH-1:0] w_nxt_top1_val;
  logic [INDEX_WIDTH-1:0] w_nxt_top1_idx;
  logic                   w_nxt_top1_vld;
  logic [VALUE_WIDTH-1:0] w_nxt_top2_val;
  logic [INDEX_WIDTH-1:0] w_nxt_top2_idx;
  logic                   w_nxt_top2_vld;

`ifdef PEAK_THRESHOLD_EN
  assign w_above_thr = (r_prev1 >= threshold);
`else
  assign w_above_thr = 1'b1;
`endif

  // prev1 is judged against both neighbours once the current beat is its right neighbour
  assign w_cand = valid && (r_beat_cnt == c_beat_full) && (r_prev1 > r_prev2) &&
                  (r_prev1 >= input_i) && w_above_thr;

  always_comb begin
    w_nxt_top1_val = r_top1_val;
    w_nxt_top1_idx = r_top1_idx;
    w_nxt_top1_vld = r_top1_vld;
    w_nxt_top2_val = r_top2_val;
    w_nxt_top2_idx = r_top2_idx;
    w_nxt_top2_vld = r_top2_vld;
    if (w_cand) begin
      if (!r_top1_vld || (r_prev1 > r_top1_val)) begin
        w_nxt_top2_val = r_top1_val;
        w_nxt_top2_idx = r_top1_idx;
        w_nxt_top2_vld = r_top1_vld;
        w_nxt_top1_val = r_prev1;
        w_nxt_top1_idx = r_prev1_idx;
        w_nxt_top1_vld = 1'b1;
      end else if (!r_top2_vld || (r_prev1 > r_top2_val)) begin
        w_nxt_top2_val = r_prev1;
        w_nxt_top2_idx = r_prev1_idx;
        w_nxt_top2_vld = 1'b1;
      end
    end
  end

  // Tracker and ranking; the closing beat clears everything so a new frame may follow at once
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_prev1     <= '0;
      r_prev2     <= '0;
      r_prev1_idx <= '0;
      r_beat_cnt  <= '0;
      r_top1_val  <= '0;
      r_top1_idx  <= '0;
      r_top1_vld  <= 1'b0;
      r_top2_val  <= '0;
      r_top2_idx  <= '0;
      r_top2_vld  <= 1'b0;
    end else if (valid) begin
      if (last) begin
        r_prev1     <= '0;
        r_prev2     <= '0;
        r_prev1_idx <= '0;
        r_beat_cnt  <= '0;
        r_top1_val  <= '0;
        r_top1_idx  <= '0;
        r_top1_vld  <= 1'b0;
        r_top2_val  <= '0;
        r_top2_idx  <= '0;
        r_top2_vld  <= 1'b0;
      end else begin
        r_prev2     <= r_prev1;
        r_prev1     <= input_i;
        r_prev1_idx <= index_i;
        if (r_beat_cnt != c_beat_full) begin
          r_beat_cnt <= r_beat_cnt + 2'd1;
        end
        r_top1_val  <= w_nxt_top1_val;
        r_top1_idx  <= w_nxt_top1_idx;
        r_top1_vld  <= w_nxt_top1_vld;
        r_top2_val  <= w_nxt_top2_val;
        r_top2_idx  <= w_nxt_top2_idx;
        r_top2_vld  <= w_nxt_top2_vld;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      p_i_s     <= {c_empty_idx, c_empty_idx};
      peak_val1 <= '0;
      peak_val2 <= '0;
      peak_cnt  <= '0;
      last_out  <= 1'b0;
    end else begin
      last_out <= valid && last;
      if (valid && last) begin
        p_i_s[31:16] <= w_nxt_top1_vld ? 16'(w_nxt_top1_idx) : c_empty_idx;
        p_i_s[15:0]  <= w_nxt_top2_vld ? 16'(w_nxt_top2_idx) : c_empty_idx;
        peak_val1    <= w_nxt_top1_vld ? w_nxt_top1_val : '0;
        peak_val2    <= w_nxt_top2_vld ? w_nxt_top2_val : '0;
        peak_cnt     <= 2'(w_nxt_top1_vld) + 2'(w_nxt_top2_vld);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_peak_pair_detect.sv
// Randomised and directed bench for peak_pair_detect against a frame-level reference model.
`default_nettype none

module tb_peak_pair_detect;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        valid = 1'b0;
  logic        last = 1'b0;
  logic [15:0] input_i = '0;
  logic [10:0] index_i = '0;
  logic [15:0] threshold = '0;
  logic [31:0] p_i_s;
  logic [15:0] peak_val1;
  logic [15:0] peak_val2;
  logic [1:0]  peak_cnt;
  logic        last_out;

  always #5 clk = ~clk;

  peak_pair_detect #(.VALUE_WIDTH(16), .INDEX_WIDTH(11)) dut (
    .clk       (clk),
    .areset    (areset),
    .valid     (valid),
    .last      (last),
    .input_i   (input_i),
    .index_i   (index_i),
`ifdef PEAK_THRESHOLD_EN
    .threshold (threshold),
`endif
    .p_i_s     (p_i_s),
    .peak_val1 (peak_val1),
    .peak_val2 (peak_val2),
    .peak_cnt  (peak_cnt),
    .last_out  (last_out)
  );

  int total = 0;
  int bad = 0;

  // Reference model: whole-frame sample lists, evaluated only when the frame closes
  int q_val[$];
  int q_idx[$];
  int q_thr[$];
  logic [31:0] exp_p = 32'hFFFF_FFFF;
  logic [15:0] exp_v1 = '0;
  logic [15:0] exp_v2 = '0;
  logic [1:0]  exp_cnt = '0;
  logic        exp_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_peak(input int i);
    return (q_val[i] > q_val[i-1]) && (q_val[i] >= q_val[i+1]) && (q_val[i] >= q_thr[i+1]);
  endfunction

  task automatic model_close();
    int n;
    int b1;
    int b2;
    n = q_val.size();
    b1 = -1;
    b2 = -1;
    for (int i = 1; i < n - 1; i++)
      if (is_peak(i) && (b1 < 0 || q_val[i] > q_val[b1])) b1 = i;
    for (int i = 1; i < n - 1; i++)
      if (i != b1 && is_peak(i) && (b2 < 0 || q_val[i] > q_val[b2])) b2 = i;
    exp_p[31:16] = (b1 >= 0) ? 16'(q_idx[b1]) : 16'hFFFF;
    exp_p[15:0]  = (b2 >= 0) ? 16'(q_idx[b2]) : 16'hFFFF;
    exp_v1  = (b1 >= 0) ? 16'(q_val[b1]) : 16'd0;
    exp_v2  = (b2 >= 0) ? 16'(q_val[b2]) : 16'd0;
    exp_cnt = 2'((b1 >= 0) ? 1 : 0) + 2'((b2 >= 0) ? 1 : 0);
    q_val.delete();
    q_idx.delete();
    q_thr.delete();
  endtask

  task automatic model_reset();
    q_val.delete();
    q_idx.delete();
    q_thr.delete();
    exp_p = 32'hFFFF_FFFF;
    exp_v1 = '0;
    exp_v2 = '0;
    exp_cnt = '0;
    exp_last = 1'b0;
  endtask

  always @(negedge clk) begin
    check("last_out", 32'(last_out), 32'(exp_last));
    check("p_i_s", p_i_s, exp_p);
    check("peak_val1", 32'(peak_val1), 32'(exp_v1));
    check("peak_val2", 32'(peak_val2), 32'(exp_v2));
    check("peak_cnt", 32'(peak_cnt), 32'(exp_cnt));
  end

  task automatic beat(input bit v, input bit l, input int val, input int idx);
    @(negedge clk);
    valid = v;
    last = l;
    input_i = 16'(val);
    index_i = 11'(idx);
    @(posedge clk);
    exp_last = 1'b0;
    if (v) begin
      q_val.push_back(val);
      q_idx.push_back(idx);
`ifdef PEAK_THRESHOLD_EN
      q_thr.push_back(int'(threshold));
`else
      q_thr.push_back(0);
`endif
      if (l) begin
        model_close();
        exp_last = 1'b1;
      end
    end
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    areset = 1'b1;
    valid = 1'b0;
    last = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    areset = 1'b0;
  endtask

  task automatic send_frame(input int vals[$]);
    for (int i = 0; i < vals.size(); i++)
      beat(1'b1, i == vals.size() - 1, vals[i], i);
  endtask

  // Literal expectations sampled just after the edge that closes the frame
  task automatic pin(input string tag, input logic [31:0] p, input int v1, input int v2, input int c);
    #1;
    check({tag, " last_out"}, 32'(last_out), 32'd1);
    check({tag, " p_i_s"}, p_i_s, p);
    check({tag, " val1"}, 32'(peak_val1), 32'(v1));
    check({tag, " val2"}, 32'(peak_val2), 32'(v2));
    check({tag, " cnt"}, 32'(peak_cnt), 32'(c));
    check({tag, " model p"}, exp_p, p);
  endtask

  initial begin
    int vals[$];
    int len;
    int big;
    repeat (2) @(negedge clk);
    #2;
    areset = 1'b0;
    idle();

    vals = '{1, 5, 2, 9, 3, 4, 0};
    send_frame(vals);
    pin("basic", 32'h0003_0001, 9, 5, 2);
    idle();

    vals = '{0, 1, 2, 3, 4, 5, 6, 7};
    send_frame(vals);
    pin("ramp", 32'hFFFF_FFFF, 0, 0, 0);

    vals = '{2, 7, 7, 1, 7, 0};
    send_frame(vals);
    pin("plateau", 32'h0001_0004, 7, 7, 2);

    vals = '{9};
    send_frame(vals);
    pin("one", 32'hFFFF_FFFF, 0, 0, 0);
    vals = '{3, 9};
    send_frame(vals);
    pin("two", 32'hFFFF_FFFF, 0, 0, 0);
    vals = '{1, 8, 2};
    send_frame(vals);
    pin("three", 32'h0001_FFFF, 8, 0, 1);
    repeat (3) idle();
    check("hold p_i_s", p_i_s, 32'h0001_FFFF);

    // valid=0 with last high must be ignored
    beat(1'b1, 1'b0, 1, 0);
    beat(1'b0, 1'b1, 50, 9);
    beat(1'b1, 1'b0, 6, 1);
    beat(1'b0, 1'b1, 0, 9);
    beat(1'b1, 1'b1, 2, 2);
    pin("gap", 32'h0001_FFFF, 6, 0, 1);

    // reset in the middle of a frame, then a clean frame
    beat(1'b1, 1'b0, 1, 0);
    beat(1'b1, 1'b0, 60, 1);
    beat(1'b1, 1'b0, 2, 2);
    do_reset();
    vals = '{4, 3, 8, 1};
    send_frame(vals);
    pin("post reset", 32'h0002_FFFF, 8, 0, 1);
    idle();

`ifdef PEAK_THRESHOLD_EN
    threshold = 16'd6;
    vals = '{1, 5, 2, 9, 3, 4, 0};
    send_frame(vals);
    pin("threshold", 32'h0003_FFFF, 9, 0, 1);
    idle();
`endif

    // back-to-back random frames with valid gaps inside
    for (int f = 0; f < 60; f++) begin
      len = $urandom_range(1, 12);
      big = $urandom_range(0, 3);
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 3) == 0)
          beat(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 65535), $urandom_range(0, 2047));
`ifdef PEAK_THRESHOLD_EN
        threshold = 16'($urandom_range(0, 8));
`endif
        beat(1'b1, i == len - 1, (big == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 7),
             $urandom_range(0, 2047));
      end
      if (f % 15 == 14) idle();
    end
    repeat (2) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/peak_pair_detect.md
PEAK_PAIR_DETECT -- requirements
Module: peak_pair_detect

Interface
REQ-001 The module SHALL have parameter VALUE_WIDTH, default 16: width of the unsigned sample magnitude.
REQ-002 The module SHALL have parameter INDEX_WIDTH, default 11: width of the bin index (legal range 2..16).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port areset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port valid, input, 1 bit: sample beat qualifier; there is no backpressure.
REQ-006 The module SHALL have port last, input, 1 bit: end of frame; it is honoured only when valid=1.
REQ-007 The module SHALL have port input_i, input, VALUE_WIDTH bits: unsigned sample magnitude.
REQ-008 The module SHALL have port index_i, input, INDEX_WIDTH bits: bin index of the current sample.
REQ-009 The module SHALL have port p_i_s, output, 32 bits: {idx1 zero-extended to 16, idx2 zero-extended to 16}.
REQ-010 The module SHALL have port peak_val1, output, VALUE_WIDTH bits: magnitude of the largest peak.
REQ-011 The module SHALL have port peak_val2, output, VALUE_WIDTH bits: magnitude of the second-largest peak.
REQ-012 The module SHALL have port peak_cnt, output, 2 bits: number of peaks found in the frame, saturating at 2.
REQ-013 The module SHALL have port last_out, output, 1 bit: one-cycle pulse indicating that the outputs above were updated.

Function
REQ-014 The module SHALL keep registers prev1, prev2 and prev1_idx, plus a frame beat counter saturating at 2; each valid beat shifts prev2<=prev1, prev1<=input_i, prev1_idx<=index_i.
REQ-015 On a valid beat with beat count 2, the module SHALL treat prev1 as a candidate when prev1 > prev2 and prev1 >= input_i (a plateau is credited to its first sample).
REQ-016 The first and last samples of a frame SHALL never be candidates; a frame of 1 or 2 beats SHALL produce peak_cnt=0.
REQ-017 Ranking: if candidate > top1, the module SHALL set top2<=top1 and top1<=candidate; else if candidate > top2, or top2 is empty, the module SHALL set top2<=candidate; otherwise the candidate SHALL be discarded. All comparisons are strict, so on ties the earlier peak is kept.
REQ-018 Candidate evaluation and ranking SHALL complete in the same cycle as the valid beat; the beat carrying last SHALL be evaluated as a right neighbour before the frame closes.
REQ-019 The cycle after a valid&&last beat, last_out SHALL be 1 for exactly one cycle, and p_i_s, peak_val1, peak_val2 and peak_cnt SHALL present the final ranking from that cycle onward.
REQ-020 Published outputs SHALL hold until the next last_out; the internal tracker, beat counter and top1/top2 SHALL clear in the same cycle last is accepted, so the next frame may start on the very next cycle.
REQ-021 An empty slot SHALL publish index 16'hFFFF and value 0 (e.g. peak_cnt=1 gives p_i_s[15:0]=16'hFFFF).
REQ-022 Beats with valid=0 SHALL change no state; last with valid=0 SHALL be ignored.

Reset
REQ-023 Asserting areset SHALL immediately clear the tracker and beat counter and set p_i_s=32'hFFFF_FFFF, peak_val1=peak_val2=0, peak_cnt=0 and last_out=0.
REQ-024 A reset during a frame SHALL abandon that frame; no last_out SHALL be produced for it, and the first valid beat after deassertion SHALL start a new frame.

Configuration
REQ-025 With macro PEAK_THRESHOLD_EN defined, the module SHALL have an extra input threshold [VALUE_WIDTH-1:0], and a candidate SHALL qualify only if prev1 >= threshold (sampled on the evaluating beat).
REQ-026 Without PEAK_THRESHOLD_EN, the threshold port SHALL be absent and every local maximum SHALL qualify.

Verification
REQ-027 A bench SHALL drive the frame 1,5,2,9,3,4,0 with indices 0..6, last on index 6 -> one cycle later: last_out=1, p_i_s=0x0003_0001, peak_val1=9, peak_val2=5, peak_cnt=2.
REQ-028 A bench SHALL drive a monotonic ramp 0..7 -> peak_cnt=0 and p_i_s=0xFFFF_FFFF.
REQ-029 A bench SHALL drive the plateau-and-tie frame 2,7,7,1,7,0 -> idx1=1, idx2=4, both values 7.
REQ-030 A bench SHALL drive back-to-back frames with no idle cycle and valid gaps inside a frame -> each frame's result matches its contents and the frames do not contaminate each other.
REQ-031 A bench SHALL assert areset at the mid-point of a frame, then send a complete frame -> exactly one last_out, reflecting only the post-reset frame.
REQ-032 With PEAK_THRESHOLD_EN defined and threshold=6, a bench SHALL repeat the REQ-027 stimulus -> peak_cnt=1, idx1=3, p_i_s[15:0]=16'hFFFF.
